frogger_game_ctrl: RTL and testbench

FROGGER_GAME_CTRL -- requirements
Module: frogger_game_ctrl

---
 rtl/frogger_pkg.sv | 21 ++
 rtl/flash_timer.sv | 40 ++++
 rtl/frogger_game_ctrl.sv | 102 ++++++++++
 tb/tb_frogger_game_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared types and default constants for the frogger game controller.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_HIT   = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam int unsigned LIVES_DEF       = 3;
  localparam int unsigned FLASH_TICKS_DEF = 4;
  localparam int unsigned WIN_SCORE_DEF   = 9;

  localparam int unsigned LIVES_W = 2;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned FLASH_W = 4;

endpackage

// File: rtl/flash_timer.sv
// Penalty tick counter: counts ticks while not cleared; done flags the last tick slot.
module flash_timer
  import frogger_pkg::*;
#(
  parameter int unsigned FLASH_TICKS = FLASH_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam logic [FLASH_W-1:0] LAST = FLASH_W'(FLASH_TICKS - 1);

  logic [FLASH_W-1:0] cnt;
  logic [FLASH_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise advance on tick and hold at the last slot.
  always_comb begin
    cnt_d = cnt;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt != LAST)) begin
      cnt_d = cnt + FLASH_W'(1);
    end
  end

  // Count register with registered terminal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      done <= (LAST == '0);
    end else begin
      cnt  <= cnt_d;
      done <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: lives/score bookkeeping and Moore-decoded control outputs.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned LIVES       = LIVES_DEF,
  parameter int unsigned FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               tick,
  input  logic               collide,
  input  logic               frog_home,
  output logic               field_clear,
  output logic               run,
  output logic               flash,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               win
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

  state_t             state, state_d;
  logic [LIVES_W-1:0] lives_d;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] score_inc;
  logic               timer_clr_c;
  logic               timer_done;

  assign timer_clr_c = (state != ST_HIT);
  assign score_inc   = score + SCORE_W'(1);

  flash_timer #(
    .FLASH_TICKS(FLASH_TICKS)
  ) u_flash_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clr_c),
    .tick   (tick),
    .done   (timer_done)
  );

  // Next-state and counter updates; collision outranks a simultaneous arrival.
  always_comb begin
    state_d = state;
    lives_d = lives;
    score_d = score;
    case (state)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start) begin
          state_d = ST_CLEAR;
          lives_d = LIVES_INIT;
          score_d = '0;
        end
      end
      ST_CLEAR: state_d = ST_PLAY;
      ST_PLAY: begin
        if (collide) begin
          state_d = ST_HIT;
          lives_d = (lives == '0) ? '0 : lives - LIVES_W'(1);
        end else if (frog_home) begin
          score_d = (score >= SCORE_WIN) ? SCORE_WIN : score_inc;
          state_d = (score_inc >= SCORE_WIN) ? ST_WIN : ST_CLEAR;
        end
      end
      ST_HIT: begin
        if (tick && timer_done) begin
          state_d = (lives == '0) ? ST_OVER : ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and outputs registered together so outputs track the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      lives       <= LIVES_INIT;
      score       <= '0;
      field_clear <= 1'b0;
      run         <= 1'b0;
      flash       <= 1'b0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_d;
      lives       <= lives_d;
      score       <= score_d;
      field_clear <= (state_d == ST_CLEAR);
      run         <= (state_d == ST_PLAY);
      flash       <= (state_d == ST_HIT);
      game_over   <= (state_d == ST_OVER);
      win         <= (state_d == ST_WIN);
    end
  end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed vector bench for frogger_game_ctrl with default parameters.
module tb_frogger_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, tick, collide, frog_home;
  logic       field_clear, run, flash, game_over, win;
  logic [1:0] lives;
  logic [3:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        s;
    logic        t;
    logic        c;
    logic        h;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  frogger_game_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .tick       (tick),
    .collide    (collide),
    .frog_home  (frog_home),
    .field_clear(field_clear),
    .run        (run),
    .flash      (flash),
    .lives      (lives),
    .score      (score),
    .game_over  (game_over),
    .win        (win)
  );

  // Packed {field_clear, run, flash, lives, score, game_over, win}
  function automatic logic [10:0] ex(input logic fc, input logic rn, input logic fl,
                                     input logic [1:0] l, input logic [3:0] sc,
                                     input logic go, input logic w);
    return {fc, rn, fl, l, sc, go, w};
  endfunction

  function automatic logic [10:0] outs();
    return {field_clear, run, flash, lives, score, game_over, win};
  endfunction

  function automatic vec_t mk(input logic s, input logic t, input logic c, input logic h,
                              input logic [10:0] e);
    vec_t v;
    v.s = s; v.t = t; v.c = c; v.h = h; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got fc=%b run=%b fl=%b lives=%0d score=%0d go=%b win=%b, want fc=%b run=%b fl=%b lives=%0d score=%0d go=%b win=%b",
               name, got[10], got[9], got[8], got[7:6], got[5:2], got[1], got[0],
               expv[10], expv[9], expv[8], expv[7:6], expv[5:2], expv[1], expv[0]);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic s, input logic t, input logic c, input logic h);
    start = s; tick = t; collide = c; frog_home = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] rst_v;
    rst_v = ex(0, 0, 0, 2'd3, 4'd0, 0, 0);

    // IDLE / CLEAR / PLAY / HIT / OVER walk-through
    vecs.push_back(mk(0, 0, 0, 0, ex(0, 0, 0, 3, 0, 0, 0)));  // idle holds
    vecs.push_back(mk(1, 0, 0, 0, ex(1, 0, 0, 3, 0, 0, 0)));  // start -> CLEAR
    vecs.push_back(mk(1, 0, 0, 0, ex(0, 1, 0, 3, 0, 0, 0)));  // PLAY, start ignored
    vecs.push_back(mk(0, 0, 1, 0, ex(0, 0, 1, 2, 0, 0, 0)));  // collide -> HIT
    vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 1, 2, 0, 0, 0)));  // tick 1
    vecs.push_back(mk(1, 0, 1, 1, ex(0, 0, 1, 2, 0, 0, 0)));  // inputs ignored in HIT
    vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 1, 2, 0, 0, 0)));  // tick 2
    vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 1, 2, 0, 0, 0)));  // tick 3
    vecs.push_back(mk(0, 1, 0, 0, ex(1, 0, 0, 2, 0, 0, 0)));  // tick 4 -> CLEAR
    vecs.push_back(mk(0, 0, 0, 0, ex(0, 1, 0, 2, 0, 0, 0)));  // PLAY
    vecs.push_back(mk(0, 0, 0, 1, ex(1, 0, 0, 2, 1, 0, 0)));  // arrival -> CLEAR
    vecs.push_back(mk(0, 0, 0, 0, ex(0, 1, 0, 2, 1, 0, 0)));  // PLAY
    vecs.push_back(mk(0, 0, 1, 1, ex(0, 0, 1, 1, 1, 0, 0)));  // both -> HIT, score kept
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 1, 1, 1, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 0, ex(1, 0, 0, 1, 1, 0, 0)));  // -> CLEAR
    vecs.push_back(mk(0, 0, 0, 0, ex(0, 1, 0, 1, 1, 0, 0)));  // PLAY
    vecs.push_back(mk(0, 0, 1, 0, ex(0, 0, 1, 0, 1, 0, 0)));  // last life lost
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 1, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 1, 0, 0, ex(0, 0, 0, 0, 1, 1, 0)));  // -> OVER
    vecs.push_back(mk(0, 1, 1, 1, ex(0, 0, 0, 0, 1, 1, 0)));  // OVER ignores play inputs
    vecs.push_back(mk(1, 0, 0, 0, ex(1, 0, 0, 3, 0, 0, 0)));  // restart reloads
    vecs.push_back(mk(0, 0, 0, 0, ex(0, 1, 0, 3, 0, 0, 0)));  // PLAY

    reset_n = 1'b0; start = 0; tick = 0; collide = 0; frog_home = 0;
    #12;
    chk("reset_state", outs(), rst_v);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].t, vecs[i].c, vecs[i].h);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Nine arrivals from PLAY with no collisions -> WIN
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 1);
      if (i < 9) begin
        chk($sformatf("arrive%0d", i), outs(), ex(1, 0, 0, 3, 4'(i), 0, 0));
        step(0, 0, 0, 0);
        chk($sformatf("replay%0d", i), outs(), ex(0, 1, 0, 3, 4'(i), 0, 0));
      end else begin
        chk("win_reached", outs(), ex(0, 0, 0, 3, 4'd9, 0, 1));
      end
    end
    step(0, 0, 0, 1);
    chk("win_holds", outs(), ex(0, 0, 0, 3, 4'd9, 0, 1));
    step(1, 0, 0, 0);
    chk("win_restart", outs(), ex(1, 0, 0, 3, 4'd0, 0, 0));
    step(0, 0, 0, 0);

    // Score to 5, then simultaneous collide and arrival
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    chk("score5_play", outs(), ex(0, 1, 0, 3, 4'd5, 0, 0));
    step(0, 0, 1, 1);
    chk("both_at5", outs(), ex(0, 0, 1, 2, 4'd5, 0, 0));

    // Finish penalty, lose another life to reach lives=1 in HIT
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("pen_clear", outs(), ex(1, 0, 0, 2, 4'd5, 0, 0));
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("hit_l1", outs(), ex(0, 0, 1, 1, 4'd5, 0, 0));
    step(0, 1, 0, 0);

    // Async reset between edges in HIT
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_hit", outs(), rst_v);
    #2 reset_n = 1'b1;
    step(0, 1, 0, 0);
    chk("post_rst1", outs(), rst_v);
    step(0, 1, 0, 0);
    chk("post_rst2", outs(), rst_v);

    // Async reset during CLEAR leaves no pulse behind
    step(1, 0, 0, 0);
    chk("clear_again", outs(), ex(1, 0, 0, 3, 4'd0, 0, 0));
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_clear", outs(), rst_v);
    #2 reset_n = 1'b1;
    step(0, 0, 0, 0);
    chk("post_rst_clear", outs(), rst_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
